cache_block_responder: RTL

Memory-side responder for the cache's block-transfer port. It accepts one block request at a time on the cache's req/rw/add command port. Reads fetch the block word-by-word from a backing word memory into an internal FIFO that the cache drains through the read port. Writes collect words the cache pushes through the write port and stream them to the backing memory. It sits between a cache's internal-memory-controller port and the external word memory.

---
 rtl/cache_block_responder.sv | 136 +++++++++++++
 1 files changed

// File: rtl/cache_block_responder.sv
// cache_block_responder: moves one cache block between the cache's FIFO port and a word-wide backing memory.
module cache_block_responder #(
  parameter int BW_ADDR  = 24,
  parameter int BW_BLOCK = 2
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               req_i,
  input  logic               rw_i,
  input  logic [BW_ADDR-1:0] add_i,
  output logic               ready_req_o,
  input  logic               write_i,
  input  logic [31:0]        data_i,
  output logic               ready_write_o,
  input  logic               read_i,
  output logic [31:0]        data_o,
  output logic               ready_read_o,
  output logic               mem_req_o,
  output logic               mem_rw_o,
  output logic [BW_ADDR-1:0] mem_addr_o,
  output logic [31:0]        mem_data_o,
  input  logic               mem_ack_i,
  input  logic [31:0]        mem_data_i,
  output logic               err_o
);
  localparam int N = 2 ** BW_BLOCK;
  localparam logic [BW_BLOCK:0] NC = (BW_BLOCK+1)'(N);
  localparam logic [BW_BLOCK:0] LAST = NC - 1'b1;
  localparam logic [BW_ADDR-1:0] OFS = BW_ADDR'(N - 1);
  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;
  state_t state_q, state_d;
  logic [BW_ADDR-1:0] base_q, base_d, mem_addr_q, mem_addr_d;
  logic [BW_BLOCK:0] issued_q, issued_d, done_q, done_d, count_q, count_d;
  logic [BW_BLOCK-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic mem_req_q, mem_req_d, mem_rw_q, mem_rw_d, err_q, err_d;
  logic [31:0] fifo_q [N];
  logic ack, push, pop, rd_ok, wr_ok;
  logic [31:0] head, push_data;
  assign head = fifo_q[rptr_q];
  always_comb begin
    ack = mem_ack_i && mem_req_q;
    rd_ok = state_q == READ && count_q != '0;
    wr_ok = state_q == WRITE && issued_q < NC && count_q < NC;
    push_data = state_q == READ ? mem_data_i : data_i;
    push = 1'b0;
    pop = 1'b0;
    state_d = state_q;
    base_d = base_q;
    issued_d = issued_q;
    done_d = done_q;
    mem_req_d = mem_req_q;
    mem_rw_d = mem_rw_q;
    mem_addr_d = mem_addr_q;
    case (state_q)
      IDLE: if (req_i) begin
        state_d = rw_i ? WRITE : READ;
        base_d = add_i & ~OFS;
        mem_rw_d = rw_i;
        done_d = '0;
        issued_d = rw_i ? '0 : (BW_BLOCK+1)'(1);
        mem_req_d = !rw_i;
        mem_addr_d = rw_i ? mem_addr_q : add_i & ~OFS;
      end
      READ: begin
        push = ack;
        pop = read_i && rd_ok;
        // A new word is only fetched once the previous one has landed, so count alone bounds FIFO space
        if (ack) mem_req_d = 1'b0;
        else if (!mem_req_q && issued_q < NC && count_q < NC) begin
          mem_req_d = 1'b1;
          mem_addr_d = base_q | BW_ADDR'(issued_q[BW_BLOCK-1:0]);
          issued_d = issued_q + 1'b1;
        end
        if (pop) done_d = done_q + 1'b1;
        if (pop && done_q == LAST) state_d = IDLE;
      end
      WRITE: begin
        push = write_i && wr_ok;
        pop = ack;
        if (push) issued_d = issued_q + 1'b1;
        if (ack) begin
          mem_req_d = 1'b0;
          done_d = done_q + 1'b1;
          if (done_q == LAST) state_d = IDLE;
        end else if (!mem_req_q && (count_q != '0 || push)) begin
          mem_req_d = 1'b1;
          mem_addr_d = base_q | BW_ADDR'(done_q[BW_BLOCK-1:0]);
        end
      end
      default: state_d = IDLE;
    endcase
    count_d = count_q + (BW_BLOCK+1)'(push) - (BW_BLOCK+1)'(pop);
    wptr_d = wptr_q + BW_BLOCK'(push);
    rptr_d = rptr_q + BW_BLOCK'(pop);
    err_d = err_q | (write_i && !wr_ok) | (read_i && !rd_ok) | (mem_ack_i && !mem_req_q);
  end
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      base_q <= '0;
      mem_addr_q <= '0;
      issued_q <= '0;
      done_q <= '0;
      count_q <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      mem_req_q <= 1'b0;
      mem_rw_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q <= base_d;
      mem_addr_q <= mem_addr_d;
      issued_q <= issued_d;
      done_q <= done_d;
      count_q <= count_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      mem_req_q <= mem_req_d;
      mem_rw_q <= mem_rw_d;
      err_q <= err_d;
    end
  end
  always_ff @(posedge clock_i) begin
    if (push) fifo_q[wptr_q] <= push_data;
  end
  assign ready_req_o = state_q == IDLE;
  assign ready_read_o = rd_ok;
  assign ready_write_o = wr_ok;
  assign data_o = rd_ok ? head : '0;
  assign mem_req_o = mem_req_q;
  assign mem_rw_o = mem_rw_q;
  assign mem_addr_o = mem_addr_q;
  assign mem_data_o = (mem_req_q && mem_rw_q) ? head : '0;
  assign err_o = err_q;
endmodule
